// File: rtl/rv_pkg.sv
// Shared rv32 core definitions: register index and data types.
package rv_pkg;

   localparam int unsigned REG_SEL_W = 5;
   localparam int unsigned XLEN      = 32;

   typedef logic [REG_SEL_W-1:0] reg_sel_t;
   typedef logic [XLEN-1:0]      xlen_t;

   localparam reg_sel_t REG_ZERO = REG_SEL_W'(0);

endpackage : rv_pkg

// File: rtl/regfile_wr_sel_decoder.sv
// Enable-gated N_SEL-bit index to one-hot decoder.
module sel_decoder #(
   parameter int unsigned N_SEL = 5
) (
   input  logic                  en,
   input  logic [N_SEL-1:0]      sel,
   output logic [(1<<N_SEL)-1:0] onehot
);

   // One bit set at sel when enabled, all clear otherwise
   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[sel] = 1'b1;
      end
   end

endmodule : sel_decoder

// File: rtl/regfile_wr.sv
// Integer register file: one write port, two bypassed read ports,
// per-register busy scoreboard with reserve handshake.
module regfile_wr
   import rv_pkg::*;
#(
   parameter int unsigned N_SEL = REG_SEL_W,
   parameter int unsigned WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [N_SEL-1:0] wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [N_SEL-1:0] rd_sel_a,
   input  logic [N_SEL-1:0] rd_sel_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             busy_a,
   output logic             busy_b,
   input  logic             rsv_valid,
   input  logic [N_SEL-1:0] rsv_sel,
   output logic             rsv_ready,
   output logic [N_SEL:0]   busy_cnt
);

   localparam int unsigned N_REG = 1 << N_SEL;
   localparam int unsigned CNT_W = N_SEL + 1;
   localparam logic [N_SEL-1:0] SEL_ZERO = N_SEL'(REG_ZERO);

   logic [WIDTH-1:0] regs [N_REG];
   logic [N_REG-1:0] busy;
   logic [N_REG-1:0] busy_next;
   logic [N_REG-1:0] wr_oh;
   logic [N_REG-1:0] rsv_oh;
   logic [CNT_W-1:0] cnt_next;
   logic             wr_live;
   logic             rsv_take;

   assign wr_live  = wr_en && (wr_sel != SEL_ZERO);
   assign rsv_take = rsv_valid && rsv_ready && (rsv_sel != SEL_ZERO);

   sel_decoder #(.N_SEL(N_SEL)) u_wr_dec (
      .en     (wr_live),
      .sel    (wr_sel),
      .onehot (wr_oh)
   );

   sel_decoder #(.N_SEL(N_SEL)) u_rsv_dec (
      .en     (rsv_take),
      .sel    (rsv_sel),
      .onehot (rsv_oh)
   );

   // Reservation is blocked only by a pending write not retiring this cycle
   always_comb begin
      rsv_ready = (rsv_sel == SEL_ZERO) || !busy[rsv_sel] ||
                  (wr_en && (wr_sel == rsv_sel));
   end

   // Read port A: zero register, then write-through bypass, then storage
   always_comb begin
      rd_data_a = '0;
      busy_a    = 1'b0;
      if (rd_sel_a != SEL_ZERO) begin
         if (wr_en && (wr_sel == rd_sel_a)) begin
            rd_data_a = wr_data;
         end else begin
            rd_data_a = regs[rd_sel_a];
            busy_a    = busy[rd_sel_a];
         end
      end
   end

   // Read port B: same rules as port A
   always_comb begin
      rd_data_b = '0;
      busy_b    = 1'b0;
      if (rd_sel_b != SEL_ZERO) begin
         if (wr_en && (wr_sel == rd_sel_b)) begin
            rd_data_b = wr_data;
         end else begin
            rd_data_b = regs[rd_sel_b];
            busy_b    = busy[rd_sel_b];
         end
      end
   end

   // Next scoreboard: write clears, then reserve sets, so a new owner wins
   always_comb begin
      busy_next = (busy & ~wr_oh) | rsv_oh;
      cnt_next  = '0;
      for (int unsigned i = 0; i < N_REG; i++) begin
         cnt_next = cnt_next + CNT_W'(busy_next[i]);
      end
   end

   // Scoreboard and its population count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_next;
         busy_cnt <= cnt_next;
      end
   end

   // Storage: at most one entry written per cycle via the one-hot enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_REG; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N_REG; i++) begin
            if (wr_oh[i]) begin
               regs[i] <= wr_data;
            end
         end
      end
   end

endmodule : regfile_wr

// File: tb/tb_regfile_wr.sv
// Self-checking bench for regfile_wr: directed plan plus random traffic
// against an array-based reference model.
module tb_regfile_wr;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [4:0]  wr_sel;
   logic [31:0] wr_data;
   logic [4:0]  rd_sel_a;
   logic [4:0]  rd_sel_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic        busy_a;
   logic        busy_b;
   logic        rsv_valid;
   logic [4:0]  rsv_sel;
   logic        rsv_ready;
   logic [5:0]  busy_cnt;

   int checks;
   int passed;

   logic [31:0] m_regs [32];
   bit          m_busy [32];

   regfile_wr #(.N_SEL(5), .WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .rd_sel_a  (rd_sel_a),
      .rd_sel_b  (rd_sel_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .busy_a    (busy_a),
      .busy_b    (busy_b),
      .rsv_valid (rsv_valid),
      .rsv_sel   (rsv_sel),
      .rsv_ready (rsv_ready),
      .busy_cnt  (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] s);
      if (s == 0) return '0;
      if (wr_en && wr_sel == s) return wr_data;
      return m_regs[s];
   endfunction

   function automatic logic exp_busy(input logic [4:0] s);
      return m_busy[s] && !(wr_en && wr_sel == s);
   endfunction

   function automatic logic exp_ready();
      return (rsv_sel == 0) || !m_busy[rsv_sel] || (wr_en && wr_sel == rsv_sel);
   endfunction

   function automatic int exp_cnt();
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   task automatic set_in(input logic we, input logic [4:0] ws, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic rv, input logic [4:0] rs);
      wr_en = we; wr_sel = ws; wr_data = wd;
      rd_sel_a = ra; rd_sel_b = rb;
      rsv_valid = rv; rsv_sel = rs;
   endtask

   // Compare every output with the model, clock once, advance the model
   task automatic step(input string tag);
      logic acc;
      #1;
      chk({tag, "_rda"},   rd_data_a, exp_rd(rd_sel_a));
      chk({tag, "_rdb"},   rd_data_b, exp_rd(rd_sel_b));
      chk({tag, "_busya"}, 32'(busy_a), 32'(exp_busy(rd_sel_a)));
      chk({tag, "_busyb"}, 32'(busy_b), 32'(exp_busy(rd_sel_b)));
      chk({tag, "_rdy"},   32'(rsv_ready), 32'(exp_ready()));
      chk({tag, "_cnt"},   32'(busy_cnt), 32'(exp_cnt()));
      acc = rsv_valid && exp_ready();
      @(posedge clk);
      if (wr_en && wr_sel != 0) begin
         m_regs[wr_sel] = wr_data;
         m_busy[wr_sel] = 1'b0;
      end
      if (acc && rsv_sel != 0) m_busy[rsv_sel] = 1'b1;
      #1;
   endtask

   task automatic pulse_reset();
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      model_reset();
      set_in(0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #12;
      chk("rst_cnt", 32'(busy_cnt), 32'd0);
      chk("rst_rdy", 32'(rsv_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: mid-cycle reset clears data and scoreboard
      set_in(1, 5, 32'hDEADBEEF, 5, 0, 1, 5);
      step("t1_wr");
      set_in(0, 0, 0, 5, 5, 0, 0);
      #1;
      chk("t1_pre_rd", rd_data_a, 32'hDEADBEEF);
      chk("t1_pre_cnt", 32'(busy_cnt), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_rst_rd", rd_data_a, 32'd0);
      chk("t1_rst_cnt", 32'(busy_cnt), 32'd0);
      chk("t1_rst_busy", 32'(busy_a), 32'd0);
      model_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 2: x0 ignores writes, x31 holds data on both ports
      set_in(1, 0, 32'h12345678, 0, 0, 0, 0);
      step("t2_w0");
      set_in(1, 31, 32'hCAFEF00D, 0, 0, 0, 0);
      step("t2_w31");
      set_in(0, 0, 0, 0, 31, 0, 0);
      #1;
      chk("t2_x0", rd_data_a, 32'd0);
      chk("t2_x31b", rd_data_b, 32'hCAFEF00D);
      step("t2_rd");
      set_in(0, 0, 0, 31, 31, 0, 0);
      #1;
      chk("t2_x31a", rd_data_a, 32'hCAFEF00D);
      step("t2_rd2");

      // 3: same-cycle bypass
      set_in(1, 7, 32'hA5A5A5A5, 7, 6, 0, 0);
      #1;
      chk("t3_byp", rd_data_a, 32'hA5A5A5A5);
      chk("t3_busy", 32'(busy_a), 32'd0);
      step("t3");

      // 4: reserve, stall, then write retires while re-reserving
      set_in(0, 0, 0, 3, 3, 1, 3);
      step("t4_rsv");
      set_in(0, 0, 0, 0, 3, 1, 3);
      #1;
      chk("t4_stall_rdy", 32'(rsv_ready), 32'd0);
      chk("t4_stall_bb", 32'(busy_b), 32'd1);
      chk("t4_stall_cnt", 32'(busy_cnt), 32'd1);
      step("t4_stall");
      set_in(1, 3, 32'h55, 0, 3, 1, 3);
      #1;
      chk("t4_wr_rdy", 32'(rsv_ready), 32'd1);
      step("t4_wr");
      set_in(0, 0, 0, 3, 3, 0, 0);
      #1;
      chk("t4_after_cnt", 32'(busy_cnt), 32'd1);
      chk("t4_after_rd", rd_data_a, 32'h55);
      chk("t4_after_busy", 32'(busy_a), 32'd1);
      step("t4_after");

      // 5: write and reserve on different indices in one cycle
      pulse_reset();
      set_in(0, 0, 0, 0, 0, 1, 4);
      step("t5_rsv4");
      set_in(1, 4, 32'h44, 4, 9, 1, 9);
      step("t5_par");
      set_in(0, 0, 0, 4, 9, 0, 0);
      #1;
      chk("t5_b4", 32'(busy_a), 32'd0);
      chk("t5_b9", 32'(busy_b), 32'd1);
      chk("t5_cnt", 32'(busy_cnt), 32'd1);
      step("t5_chk");

      // 6: fill every register, x0 stays reservable
      pulse_reset();
      for (int i = 1; i < 32; i++) begin
         set_in(0, 0, 0, 5'(i), 5'(i - 1), 1, 5'(i));
         step("t6_fill");
      end
      set_in(0, 0, 0, 0, 17, 1, 0);
      #1;
      chk("t6_full_cnt", 32'(busy_cnt), 32'd31);
      chk("t6_x0_rdy", 32'(rsv_ready), 32'd1);
      step("t6_x0");
      set_in(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("t6_cnt_hold", 32'(busy_cnt), 32'd31);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         set_in(1'($urandom_range(0, 2) != 0), 5'($urandom), $urandom,
                5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom));
         if ($urandom_range(0, 7) == 0) wr_sel = rd_sel_a;
         if ($urandom_range(0, 7) == 0) rsv_sel = wr_sel;
         step("rnd");
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_regfile_wr
